// File: rtl/copro_sysctl.sv
// rtl/copro_sysctl.sv - tube co-processor system controller: reset, boot overlay, decode, RAM wait states, IRQ sync
//
// Ports:
//   clk_cpu, rst_b          parasite clock, asynchronous active-low reset
//   clken_in                free-running CPU clock enable
//   ext_rst_b               tube parasite reset (level, active-low)
//   cpu_addr, cpu_rdnw      CPU bus address and direction (1 = read)
//   cpu_clken               gated clock enable to the CPU core (stalls on RAM)
//   cpu_rst_b               registered CPU reset, active-low
//   nmi_n_in, irq_n_in      raw interrupt sources, active-low
//   cpu_nmi_n, cpu_irq_n    interrupts sampled on cpu_clken
//   tube_cs_b, rom_cs_b, ram_cs_b   active-low selects
//   bootmode                boot ROM overlay active
//   tube_dout, rom_dout, ram_dout   read data sources
//   cpu_din                 CPU read data
//   ram_req, ram_we, ram_ack        external RAM handshake

module copro_sysctl #(
    parameter int          ADDR_W    = 16,
    parameter int          ROM_AW    = 11,
    parameter logic [23:0] TUBE_BASE = 24'h00FEF8,
    parameter int          RST_CNT_W = 9,
    parameter int          NIRQ      = 1,
    parameter int          RAM_HS    = 1
) (
    input  logic              clk_cpu,
    input  logic              rst_b,
    input  logic              clken_in,
    input  logic              ext_rst_b,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rdnw,
    output logic              cpu_clken,
    output logic              cpu_rst_b,
    input  logic              nmi_n_in,
    input  logic [NIRQ-1:0]   irq_n_in,
    output logic              cpu_nmi_n,
    output logic              cpu_irq_n,
    output logic              tube_cs_b,
    output logic              rom_cs_b,
    output logic              ram_cs_b,
    output logic              bootmode,
    input  logic [7:0]        tube_dout,
    input  logic [7:0]        rom_dout,
    input  logic [7:0]        ram_dout,
    output logic [7:0]        cpu_din,
    output logic              ram_req,
    output logic              ram_we,
    input  logic              ram_ack
);

    logic [RST_CNT_W-1:0] rst_cnt;
    logic                 tube_hit;
    logic                 rom_hit;
    logic                 ram_hit;
    logic                 upper_zero;
    logic                 clken_g;
    logic [7:0]           ram_data;
    logic                 unused_addr;

    // Low address bits only matter to the selected device, not to the decode.
    assign unused_addr = ^cpu_addr[ROM_AW-1:0];

    // Power-up counter: runs until its MSB sets and then parks there, so an
    // ext_rst_b pulse later on releases the CPU on the very next clock.
    always_ff @(posedge clk_cpu or negedge rst_b) begin
        if (!rst_b) begin
            rst_cnt   <= '0;
            cpu_rst_b <= 1'b0;
        end else begin
            if (!rst_cnt[RST_CNT_W-1]) begin
                rst_cnt <= rst_cnt + 1'b1;
            end
            cpu_rst_b <= ext_rst_b & rst_cnt[RST_CNT_W-1];
        end
    end

    // The ROM lives in bank 0 only; 24-bit parasites see RAM above it.
    generate
        if (ADDR_W > 16) begin : g_upper
            assign upper_zero = ~|cpu_addr[ADDR_W-1:16];
        end else begin : g_no_upper
            assign upper_zero = 1'b1;
        end
    endgenerate

    assign tube_hit = (cpu_addr[ADDR_W-1:3] == TUBE_BASE[ADDR_W-1:3]);
    // Only reads see the overlay; writes in the ROM window fall through to RAM.
    assign rom_hit  = bootmode & cpu_rdnw & (&cpu_addr[15:ROM_AW]) & upper_zero & ~tube_hit;
    assign ram_hit  = ~tube_hit & ~rom_hit;

    assign tube_cs_b = ~(tube_hit & cpu_clken);
    assign rom_cs_b  = ~rom_hit;
    assign ram_cs_b  = ~ram_hit;
    assign cpu_clken = clken_g;

    always_comb begin
        cpu_din = ram_data;
        if (tube_hit) begin
            cpu_din = tube_dout;
        end else if (rom_hit) begin
            cpu_din = rom_dout;
        end
    end

    // The first completed tube access means the client has taken over and the
    // boot ROM is no longer needed; only a reset brings the overlay back.
    always_ff @(posedge clk_cpu or negedge rst_b) begin
        if (!rst_b) begin
            bootmode <= 1'b1;
        end else if (!cpu_rst_b) begin
            bootmode <= 1'b1;
        end else if (tube_hit && clken_g) begin
            bootmode <= 1'b0;
        end
    end

    // Interrupts are sampled with the CPU enable so they freeze while stalled.
    always_ff @(posedge clk_cpu or negedge rst_b) begin
        if (!rst_b) begin
            cpu_nmi_n <= 1'b1;
            cpu_irq_n <= 1'b1;
        end else if (!cpu_rst_b) begin
            cpu_nmi_n <= 1'b1;
            cpu_irq_n <= 1'b1;
        end else if (clken_g) begin
            cpu_nmi_n <= nmi_n_in;
            cpu_irq_n <= &irq_n_in;
        end
    end

    generate
        if (RAM_HS != 0) begin : g_hs
            typedef enum logic [1:0] {
                S_IDLE = 2'd0,
                S_REQ  = 2'd1,
                S_DONE = 2'd2
            } state_t;

            state_t     state;
            logic       req_q;
            logic [7:0] rdata;

            always_ff @(posedge clk_cpu or negedge rst_b) begin
                if (!rst_b) begin
                    state <= S_IDLE;
                    req_q <= 1'b0;
                    rdata <= 8'h00;
                end else if (!cpu_rst_b) begin
                    // Abandon any outstanding request; a late ack lands in IDLE
                    // and is ignored there.
                    state <= S_IDLE;
                    req_q <= 1'b0;
                end else begin
                    case (state)
                        S_IDLE: begin
                            if (clken_in && ram_hit) begin
                                state <= S_REQ;
                                req_q <= 1'b1;
                            end
                        end
                        S_REQ: begin
                            if (ram_ack) begin
                                rdata <= ram_dout;
                                state <= S_DONE;
                                req_q <= 1'b0;
                            end
                        end
                        S_DONE: begin
                            if (clken_in) begin
                                state <= S_IDLE;
                            end
                        end
                        default: begin
                            state <= S_IDLE;
                            req_q <= 1'b0;
                        end
                    endcase
                end
            end

            // The RAM cycle is held off until DONE, where the next free-running
            // enable completes it with the latched data on cpu_din.
            always_comb begin
                clken_g = 1'b0;
                case (state)
                    S_IDLE:  clken_g = clken_in & ~ram_hit;
                    S_REQ:   clken_g = 1'b0;
                    S_DONE:  clken_g = clken_in;
                    default: clken_g = 1'b0;
                endcase
            end

            assign ram_req  = req_q;
            assign ram_we   = req_q & ~cpu_rdnw;
            assign ram_data = rdata;
        end else begin : g_zero_wait
            logic unused_ack;

            assign unused_ack = ram_ack;
            assign clken_g    = clken_in;
            assign ram_req    = ram_hit & clken_in;
            assign ram_we     = ram_hit & clken_in & ~cpu_rdnw;
            assign ram_data   = ram_dout;
        end
    endgenerate

endmodule

// File: doc/copro_sysctl.md
# copro_sysctl

Parametrised system controller for the tube co-processors. It generates the power-up and tube reset for the parasite CPU and runs the boot-ROM overlay and the address decode for tube, ROM and RAM. It also synchronises the interrupt sources and provides a req/ack wait-state handshake, so external RAM with variable latency (SDRAM, shared BRAM) can stall the CPU clock enable. It sits between the parasite CPU core, the tube, the tube boot ROM and the external RAM port, for both 16-bit (6502/65C102) and 24-bit (65816) parasites.

## Interface
- ADDR_W, 16, CPU address width (16..24).
- ROM_AW, 11, boot ROM address width; ROM is the top 2^ROM_AW bytes of bank 0.
- TUBE_BASE, 24'h00FEF8, base of the 8-byte tube register window; only bits [ADDR_W-1:3] are compared.
- RST_CNT_W, 9, power-up counter width; reset is held for 2^(RST_CNT_W-1) cycles.
- NIRQ, 1, number of active-low IRQ sources.
- RAM_HS, 1, 1 = req/ack handshake with stall; 0 = zero-wait mode (no FSM, no stall).

Ports:
- clk_cpu  in  1  parasite clock.
- rst_b  in  1  asynchronous active-low reset.
- clken_in  in  1  free-running CPU clock enable.
- ext_rst_b  in  1  tube parasite reset (p_rst_b), level.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_rdnw  in  1  1 = read.
- cpu_clken  out  1  gated clock enable to the CPU core.
- cpu_rst_b  out  1  registered CPU reset, active-low.
- nmi_n_in  in  1  tube NMI.
- irq_n_in  in  NIRQ  IRQ sources.
- cpu_nmi_n, cpu_irq_n  out  1  synchronised interrupts.
- tube_cs_b, rom_cs_b, ram_cs_b  out  1  selects.
- bootmode  out  1  ROM overlay active.
- tube_dout, rom_dout, ram_dout  in  8  read data sources.
- cpu_din  out  8  CPU read data.
- ram_req, ram_we  out  1  RAM request, write strobe.
- ram_ack  in  1  RAM completion.

## Operation
- **Async reset (rst_b=0):**
  - Counter clears.
  - Outputs: cpu_rst_b=0, bootmode=1, cpu_nmi_n=cpu_irq_n=1, ram_req=0.
  - FSM goes to IDLE and the read-data register clears to 8'h00.
- **Reset generation:**
  - Counter increments each clk_cpu until its MSB sets, then holds.
  - cpu_rst_b <= ext_rst_b & cnt[MSB], registered.
  - ext_rst_b does not clear the counter.
  - While cpu_rst_b=0: bootmode<=1, the interrupt syncs <=1, FSM<=IDLE, ram_req<=0.
- **Decode:**
  - tube_hit = cpu_addr[ADDR_W-1:3]==TUBE_BASE[ADDR_W-1:3].
  - rom_hit = bootmode & cpu_rdnw & cpu_addr[15:ROM_AW] all ones & (upper bits above 15 zero when ADDR_W>16) & ~tube_hit.
  - ram_hit = ~tube_hit & ~rom_hit. Writes to the ROM region go to RAM.
- **Select outputs:**
  - tube_cs_b = ~(tube_hit & cpu_clken).
  - rom_cs_b = ~rom_hit.
  - ram_cs_b = ~ram_hit.
- **cpu_din:** priority tube_dout, then rom_dout, then RAM data (rdata register when RAM_HS=1, ram_dout when 0).
- **bootmode:** clears on the first clock where tube_hit & cpu_clken. It sets again only on reset.
- **Wait FSM (RAM_HS=1), states IDLE, REQ, DONE:**
  - IDLE: cpu_clken = clken_in & ~ram_hit. On clken_in & ram_hit, go to REQ.
  - REQ: ram_req=1, ram_we=~cpu_rdnw, cpu_clken=0. On ram_ack, latch ram_dout into rdata and go to DONE.
  - DONE: ram_req=0. cpu_clken = clken_in. On clken_in, go to IDLE; that enable completes the CPU cycle with rdata on cpu_din.
- **RAM_HS=0:** cpu_clken=clken_in, ram_req=ram_hit & clken_in, ram_we=ram_req & ~cpu_rdnw.
- **Interrupts:** on cpu_clken, cpu_nmi_n<=nmi_n_in and cpu_irq_n<=&irq_n_in. Values hold during stalls.

## Timing
- Power-up: cpu_rst_b rises 2^(RST_CNT_W-1)+1 clocks after rst_b deasserts, provided ext_rst_b=1.
- Handshake, minimum path:
  - clken_in & ram_hit at T: stall.
  - ram_req high from T+1.
  - ram_ack at T+1 gives DONE at T+2.
  - The CPU cycle completes at the first clken_in at or after T+2.
- ram_ack is ignored outside REQ. ram_req stays high until ack, with no timeout.
- cpu_rst_b falling during REQ: ram_req drops on the next clock and the FSM goes to IDLE. A late ram_ack is ignored.
- Tube and ROM accesses never stall.
- Interrupt latency: one cpu_clken.

## Test plan
- **Power-up:** RST_CNT_W=9, hold rst_b low, then release.
  - Expect cpu_rst_b=0 for 256 clocks, then 1 at clock 257.
  - Pulse ext_rst_b low: cpu_rst_b=0 the next clock; the counter is not restarted.
- **Boot overlay:**
  - Read 16'hF800: rom_cs_b=0 and cpu_din=rom_dout.
  - Write 16'hF800: ram_we=1.
  - Read 16'hFEF8: tube_cs_b=0.
  - Read 16'hF800 again: ram_cs_b=0 and bootmode=0.
- **Wait states:** RAM read at 16'h1234 with ram_ack delayed 5 clocks.
  - Expect cpu_clken low throughout REQ and ram_req high for exactly 5 clocks.
  - Expect cpu_din=8'hA5 (the ram_dout value at ack) on the completing enable.
- **Reset mid-request:** pull ext_rst_b low during REQ.
  - Expect ram_req=0 and FSM IDLE one clock after cpu_rst_b falls.
- **Interrupts:** NIRQ=3, irq_n_in=3'b101 during a stall.
  - Expect cpu_irq_n to stay at 1 until the next cpu_clken, then become 0.
- **ADDR_W=24:** read 24'h01F800.
  - Expect a RAM access (not ROM); 24'h00FEF8 decodes as tube.
